// File: rtl/i3c2_pkg.sv
// Shared definitions for the I2C read-back bank: geometry, dump FSM encoding,
// frame header and status-byte layout.
package i3c2_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 32;

  localparam logic [DATA_W-1:0] HEADER_BYTE_DEF = 8'hA5;

  // Status byte: {err, 1'b0, entry_count[5:0]}
  localparam int unsigned STAT_ERR_BIT = 7;
  localparam int unsigned STAT_CNT_LSB = 0;
  localparam int unsigned STAT_CNT_W   = 6;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_STAT = 3'd2,
    ST_SCAN = 3'd3,
    ST_ADDR = 3'd4,
    ST_DATA = 3'd5,
    ST_TRL  = 3'd6
  } dump_state_e;

  // Entry count is kept modulo 64, so a full bank reads back as 6'd32.
  function automatic logic [DATA_W-1:0] status_byte(input logic err,
                                                    input logic [DEPTH-1:0] snap);
    logic [STAT_CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      cnt = cnt + STAT_CNT_W'(snap[i]);
    end
    status_byte = '0;
    status_byte[STAT_ERR_BIT] = err;
    status_byte[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
  endfunction

endpackage

// File: rtl/i3c2_readback_bank_if.sv
// Byte stream from the read-back bank dump engine to the debug UART transmitter.
interface i3c2_readback_bank_if;
  import i3c2_pkg::*;

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/i3c2_byte_tx_reg.sv
// One-entry output holding register: a new byte or a drop of valid is only
// accepted when the register is empty or its byte is transferring this cycle.
module i3c2_byte_tx_reg
  import i3c2_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              drop,
  input  logic [DATA_W-1:0] din,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  logic accept_c;
  assign accept_c = !valid || ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (accept_c) begin
      if (load) begin
        data  <= din;
        valid <= 1'b1;
      end else if (drop) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/i3c2_readback_bank.sv
// Captures sequencer read-back values into a 32x8 bank, offers a registered
// random-read port and dumps the valid entries as a framed byte stream.
module i3c2_readback_bank
  import i3c2_pkg::*;
#(
  parameter logic [7:0]  HEADER_BYTE = HEADER_BYTE_DEF,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    reg_addr,
  input  logic [DATA_W-1:0]    reg_data,
  input  logic                 reg_write,
  input  logic                 cpu_error,
  input  logic                 clear,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DATA_W-1:0]    rd_data,
  output logic [DEPTH-1:0]     valid_mask,
  output logic [CNT_W-1:0]     write_count,
  output logic                 err_sticky,
  input  logic                 dump_req,
  output logic                 busy,
  i3c2_readback_bank_if.master tx
);

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] bank [DEPTH];

  dump_state_e       state, state_n;
  logic [DEPTH-1:0]  snap, snap_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic [DATA_W-1:0] csum, csum_n;
  logic              busy_n;
  logic              tx_load_c, tx_drop_c, xfer_c;
  logic [DATA_W-1:0] tx_din_c;

  // Bank contents survive reset; only the bookkeeping is cleared.
  always_ff @(posedge clk) begin
    if (reg_write) bank[reg_addr] <= reg_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= bank[rd_addr];
  end

  // A capture in the same cycle as clear still lands and is counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_mask  <= '0;
      write_count <= '0;
      err_sticky  <= 1'b0;
    end else begin
      if (clear) begin
        valid_mask  <= '0;
        write_count <= reg_write ? CNT_W'(1) : '0;
      end else if (reg_write && write_count != CNT_MAX) begin
        write_count <= write_count + CNT_W'(1);
      end
      if (reg_write) valid_mask[reg_addr] <= 1'b1;
      if (cpu_error) err_sticky <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      snap  <= '0;
      idx   <= '0;
      csum  <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      snap  <= snap_n;
      idx   <= idx_n;
      csum  <= csum_n;
      busy  <= busy_n;
    end
  end

  assign xfer_c = tx.tx_valid && tx.tx_ready;

  always_comb begin
    state_n   = state;
    snap_n    = snap;
    idx_n     = idx;
    csum_n    = csum;
    busy_n    = busy;
    tx_load_c = 1'b0;
    tx_drop_c = 1'b0;
    tx_din_c  = '0;
    case (state)
      ST_IDLE: if (dump_req) begin
        snap_n    = valid_mask;
        idx_n     = '0;
        csum_n    = '0;
        busy_n    = 1'b1;
        tx_load_c = 1'b1;
        tx_din_c  = HEADER_BYTE;
        state_n   = ST_HDR;
      end
      ST_HDR: if (xfer_c) begin
        tx_load_c = 1'b1;
        tx_din_c  = status_byte(err_sticky, snap);
        state_n   = ST_STAT;
      end
      ST_STAT: if (xfer_c) begin
        csum_n    = csum ^ tx.tx_data;
        tx_drop_c = 1'b1;
        state_n   = ST_SCAN;
      end
      ST_SCAN: begin
        if (snap[idx]) begin
          tx_load_c = 1'b1;
          tx_din_c  = DATA_W'(idx);
          state_n   = ST_ADDR;
        end else if (idx == IDX_LAST) begin
          tx_load_c = 1'b1;
          tx_din_c  = csum;
          state_n   = ST_TRL;
        end else begin
          idx_n = idx + ADDR_W'(1);
        end
      end
      // Data is read live from the bank when the address byte goes out.
      ST_ADDR: if (xfer_c) begin
        csum_n    = csum ^ tx.tx_data;
        tx_load_c = 1'b1;
        tx_din_c  = bank[idx];
        state_n   = ST_DATA;
      end
      ST_DATA: if (xfer_c) begin
        csum_n = csum ^ tx.tx_data;
        if (idx == IDX_LAST) begin
          tx_load_c = 1'b1;
          tx_din_c  = csum_n;
          state_n   = ST_TRL;
        end else begin
          tx_drop_c = 1'b1;
          idx_n     = idx + ADDR_W'(1);
          state_n   = ST_SCAN;
        end
      end
      ST_TRL: if (xfer_c) begin
        tx_drop_c = 1'b1;
        busy_n    = 1'b0;
        state_n   = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  i3c2_byte_tx_reg u_tx_reg (
    .clk   (clk),
    .rst   (rst),
    .load  (tx_load_c),
    .drop  (tx_drop_c),
    .din   (tx_din_c),
    .ready (tx.tx_ready),
    .data  (tx.tx_data),
    .valid (tx.tx_valid)
  );

endmodule

// File: tb/tb_i3c2_readback_bank.sv
// Scoreboard bench for i3c2_readback_bank: expected frame bytes are queued by
// the stimulus thread and popped by a monitor on every stream handshake.
module tb_i3c2_readback_bank;
  import i3c2_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] reg_addr;
  logic [7:0] reg_data;
  logic       reg_write;
  logic       cpu_error;
  logic       clear;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [31:0] valid_mask;
  logic [7:0] write_count;
  logic       err_sticky;
  logic       dump_req;
  logic       busy;

  i3c2_readback_bank_if tx_if ();

  i3c2_readback_bank dut (
    .clk         (clk),
    .rst         (rst),
    .reg_addr    (reg_addr),
    .reg_data    (reg_data),
    .reg_write   (reg_write),
    .cpu_error   (cpu_error),
    .clear       (clear),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .valid_mask  (valid_mask),
    .write_count (write_count),
    .err_sticky  (err_sticky),
    .dump_req    (dump_req),
    .busy        (busy),
    .tx          (tx_if)
  );

  always #5 clk = ~clk;

  int         n_total = 0;
  int         n_pass  = 0;
  logic [7:0] exp_q[$];
  bit         throttle = 1'b0;
  bit         held_valid = 1'b0;
  logic [7:0] held_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                            input logic [7:0] b6, input int n);
    logic [7:0] v [7];
    v = '{b0, b1, b2, b3, b4, b5, b6};
    for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
  endtask

  task automatic start_dump();
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_done"}, 32'(ok), 32'd1);
    repeat (3) tick();
    check({name, "_idle"}, 32'(busy), 32'd0);
    check({name, "_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Stream monitor: byte scoreboard plus stable-while-stalled check.
  initial begin
    forever begin
      @(negedge clk);
      if (held_valid) begin
        check("stall_valid", 32'(tx_if.tx_valid), 32'd1);
        check("stall_data", 32'(tx_if.tx_data), 32'(held_data));
      end
      if (tx_if.tx_valid === 1'b1 && tx_if.tx_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL tx_extra: got %h expected no byte", tx_if.tx_data);
        end else begin
          check("tx_byte", 32'(tx_if.tx_data), 32'(exp_q.pop_front()));
        end
      end
      held_valid = (tx_if.tx_valid === 1'b1) && (tx_if.tx_ready !== 1'b1);
      held_data  = tx_if.tx_data;
    end
  end

  // Ready driver: always ready, or ready one cycle in three when throttled.
  initial begin
    int ph;
    ph = 0;
    tx_if.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (throttle) begin
        ph = (ph + 1) % 3;
        tx_if.tx_ready = (ph == 0);
      end else begin
        tx_if.tx_ready = 1'b1;
      end
    end
  end

  initial begin
    bit found;
    rst = 1'b1; reg_addr = '0; reg_data = '0; reg_write = 1'b0;
    cpu_error = 1'b0; clear = 1'b0; rd_addr = '0; dump_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mask", valid_mask, 32'd0);
    check("rst_count", 32'(write_count), 32'd0);
    check("rst_err", 32'(err_sticky), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_valid", 32'(tx_if.tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_if.tx_data), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    // Two captures and a random read.
    reg_write = 1'b1; reg_addr = 5'd3;  reg_data = 8'h12; tick();
    reg_addr = 5'd17; reg_data = 8'h80; tick();
    reg_write = 1'b0; rd_addr = 5'd17; tick();
    check("cap_mask", valid_mask, 32'h0002_0008);
    check("cap_count", 32'(write_count), 32'd2);
    check("rd_17", 32'(rd_data), 32'h80);

    // Read colliding with a capture returns the old value.
    rd_addr = 5'd3; reg_write = 1'b1; reg_addr = 5'd3; reg_data = 8'h55; tick();
    check("rd_old", 32'(rd_data), 32'h12);
    reg_write = 1'b0; tick();
    check("rd_new", 32'(rd_data), 32'h55);
    reg_write = 1'b1; reg_data = 8'h12; tick();
    reg_write = 1'b0;

    push_frame(8'hA5, 8'h02, 8'h03, 8'h12, 8'h11, 8'h80, 8'h82, 7);
    start_dump();
    wait_done("dump_full_rate");

    throttle = 1'b1;
    push_frame(8'hA5, 8'h02, 8'h03, 8'h12, 8'h11, 8'h80, 8'h82, 7);
    start_dump();
    wait_done("dump_throttled");
    throttle = 1'b0;
    tick();

    clear = 1'b1; tick(); clear = 1'b0;
    check("clr_mask", valid_mask, 32'd0);
    check("clr_count", 32'(write_count), 32'd0);
    push_frame(8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3);
    start_dump();
    wait_done("dump_empty");

    cpu_error = 1'b1; tick(); cpu_error = 1'b0; tick();
    check("err_sticky", 32'(err_sticky), 32'd1);
    push_frame(8'hA5, 8'h80, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 3);
    start_dump();
    wait_done("dump_empty_err");

    // Capture and a second dump_req during a dump of {3}.
    clear = 1'b1; tick(); clear = 1'b0;
    reg_write = 1'b1; reg_addr = 5'd3; reg_data = 8'h12; tick();
    reg_write = 1'b0;
    push_frame(8'hA5, 8'h81, 8'h03, 8'h12, 8'h90, 8'h00, 8'h00, 5);
    start_dump();
    reg_write = 1'b1; reg_addr = 5'd5; reg_data = 8'h77; tick();
    reg_write = 1'b0;
    start_dump();
    wait_done("dump_snapshot");
    check("snap_mask", valid_mask, 32'h0000_0028);

    for (int i = 0; i < 300; i++) begin
      reg_write = 1'b1; reg_addr = 5'(i); reg_data = 8'(i); tick();
    end
    reg_write = 1'b0;
    check("sat_count", 32'(write_count), 32'd255);

    clear = 1'b1; reg_write = 1'b1; reg_addr = 5'd9; reg_data = 8'h3C; tick();
    clear = 1'b0; reg_write = 1'b0;
    check("clrwr_mask", valid_mask, 32'h0000_0200);
    check("clrwr_count", 32'(write_count), 32'd1);

    // Reset while the data byte of entry 9 is on the stream.
    push_frame(8'hA5, 8'h81, 8'h09, 8'h3C, 8'h00, 8'h00, 8'h00, 4);
    start_dump();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (tx_if.tx_valid === 1'b1 && tx_if.tx_data === 8'h3C) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_data", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_tx_valid", 32'(tx_if.tx_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_tx_data", 32'(tx_if.tx_data), 32'd0);
    check("abort_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("post_rst_mask", valid_mask, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
